// File: rtl/irq_grant_capture_if.sv
// Consumer-side handshake for irq_grant_capture.
// master: record source (valid/bus/chan out, ready in); slave: dispatcher.
interface irq_grant_capture_if;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_bus;
    logic [3:0] out_chan;

    modport master (
        output out_valid,
        output out_bus,
        output out_chan,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_bus,
        input  out_chan,
        output out_ready
    );
endinterface

// File: rtl/irq_grant_capture.sv
// Debounces interrupt decoder grants and queues each settled {bus, chan}.
// Ports: clk, rst (async high), pa/pb/pc/chan decoder inputs,
//   out (master handshake: out_valid/out_ready/out_bus/out_chan),
//   fifo_count, overflow (sticky drop flag), clr_ovf (sync clear).
module irq_grant_capture #(
    parameter int DEPTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pa,
    input  logic                 pb,
    input  logic                 pc,
    input  logic [3:0]           chan,
    irq_grant_capture_if.master  out,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    state_t        state;
    logic [2:0]    req_q;
    logic [3:0]    chan_q;
    logic [5:0]    snap;
    logic [SW-1:0] cnt;

    logic          active;
    logic [1:0]    bus;
    logic [5:0]    key;
    logic          match;
    logic          settled;

    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= 3'd0;
            chan_q <= 4'd0;
        end else begin
            req_q  <= {pa, pb, pc};
            chan_q <= chan;
        end
    end

    assign active = |req_q;

    always_comb begin
        bus = 2'd0;
        if (req_q[2])
            bus = 2'd0;
        else if (req_q[1])
            bus = 2'd1;
        else if (req_q[0])
            bus = 2'd2;
    end

    // Channel is meaningless without a request, so it is masked out.
    assign key     = active ? {bus, chan_q} : 6'd0;
    assign match   = (key == snap);
    assign settled = (state == SETTLE) && active && match &&
                     (cnt == SW'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            snap  <= 6'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        state <= SETTLE;
                        snap  <= key;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (!match) begin
                        snap <= key;
                        cnt  <= '0;
                    end else if (cnt == SW'(STABLE_CYCLES - 1)) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + SW'(1);
                    end
                end
                HELD: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (!match) begin
                        state <= SETTLE;
                        snap  <= key;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full  = (fifo_count == CNT_W'(DEPTH));
    assign empty = (fifo_count == '0);
    assign pop   = !empty && out.out_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push  = settled && (!full || pop);
    assign drop  = settled && full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= snap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign out.out_valid = !empty;
    assign out.out_bus   = empty ? 2'd0 : mem[rd_ptr][5:4];
    assign out.out_chan  = empty ? 4'd0 : mem[rd_ptr][3:0];

endmodule

// File: tb/tb_irq_grant_capture.sv
// Directed bench for irq_grant_capture with hand-computed expectations.
// Ports exercised: decoder inputs, handshake interface, count/overflow.
module tb_irq_grant_capture;

    logic       clk;
    logic       rst;
    logic       pa;
    logic       pb;
    logic       pc;
    logic [3:0] chan;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_ovf;

    int checks;
    int errors;
    int max_cnt;

    irq_grant_capture_if ifc ();

    irq_grant_capture #(
        .DEPTH         (4),
        .STABLE_CYCLES (2),
        .CNT_W         (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pa         (pa),
        .pb         (pb),
        .pc         (pc),
        .chan       (chan),
        .out        (ifc.master),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic a, input logic b, input logic c,
                          input logic [3:0] ch);
        pa   = a;
        pb   = b;
        pc   = c;
        chan = ch;
    endtask

    task automatic push_rec(input logic [3:0] ch);
        set_in(1'b0, 1'b0, 1'b1, ch);
        repeat (5) tick();
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) tick();
    endtask

    task automatic drain();
        ifc.out_ready = 1'b1;
        repeat (5) tick();
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clr_ovf = 1'b0;
        ifc.out_ready = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) tick();

        chk("rst_valid", 32'(ifc.out_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_bus", 32'(ifc.out_bus), 0);
        chk("rst_chan", 32'(ifc.out_chan), 0);
        rst = 1'b0;
        tick();

        // Basic capture: valid rises after the 4th edge.
        set_in(1'b0, 1'b1, 1'b0, 4'd5);
        repeat (3) tick();
        chk("basic_lat3", 32'(ifc.out_valid), 0);
        tick();
        chk("basic_lat4", 32'(ifc.out_valid), 1);
        chk("basic_bus", 32'(ifc.out_bus), 1);
        chk("basic_chan", 32'(ifc.out_chan), 5);
        repeat (4) tick();
        chk("basic_norepush", 32'(fifo_count), 1);
        chk("basic_hold", 32'(ifc.out_chan), 5);
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("basic_pop_cnt", 32'(fifo_count), 0);
        chk("basic_pop_valid", 32'(ifc.out_valid), 0);
        chk("basic_empty_bus", 32'(ifc.out_bus), 0);
        chk("basic_empty_chan", 32'(ifc.out_chan), 0);
        repeat (2) tick();

        // Glitch filter: one cycle of chan=3, then chan=7.
        set_in(1'b1, 1'b0, 1'b0, 4'd3);
        tick();
        chan = 4'd7;
        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (int'(fifo_count) > max_cnt)
                max_cnt = int'(fifo_count);
        end
        chk("glitch_max", 32'(max_cnt), 1);
        chk("glitch_bus", 32'(ifc.out_bus), 0);
        chk("glitch_chan", 32'(ifc.out_chan), 7);
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        drain();

        // Priority: all flags set, bus A wins.
        set_in(1'b1, 1'b1, 1'b1, 4'd9);
        repeat (6) tick();
        chk("prio_cnt", 32'(fifo_count), 1);
        chk("prio_bus", 32'(ifc.out_bus), 0);
        chk("prio_chan", 32'(ifc.out_chan), 9);
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        drain();
        chk("prio_drained", 32'(fifo_count), 0);

        // Overflow: five records into a 4-deep FIFO.
        for (int k = 1; k <= 5; k++)
            push_rec(4'(k));
        chk("ovf_cnt", 32'(fifo_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain_valid", 32'(ifc.out_valid), 1);
            chk("ovf_drain_bus", 32'(ifc.out_bus), 2);
            chk("ovf_drain_chan", 32'(ifc.out_chan), 32'(k));
            ifc.out_ready = 1'b1;
            tick();
            ifc.out_ready = 1'b0;
        end
        chk("ovf_empty", 32'(fifo_count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Full FIFO with a pop on the settling edge.
        for (int k = 1; k <= 4; k++)
            push_rec(4'(k));
        chk("full_pre_cnt", 32'(fifo_count), 4);
        set_in(1'b0, 1'b0, 1'b1, 4'd6);
        repeat (3) tick();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("full_pop_cnt", 32'(fifo_count), 4);
        chk("full_pop_ovf", 32'(overflow), 0);
        chk("full_pop_head", 32'(ifc.out_chan), 2);
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            chk("full_order", 32'(ifc.out_chan),
                (k == 3) ? 32'd6 : 32'(k + 2));
            ifc.out_ready = 1'b1;
            tick();
            ifc.out_ready = 1'b0;
        end
        chk("full_drained", 32'(fifo_count), 0);

        // Reset mid-settle with two records queued.
        push_rec(4'd1);
        push_rec(4'd2);
        chk("mid_pre_cnt", 32'(fifo_count), 2);
        set_in(1'b0, 1'b1, 1'b0, 4'd8);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ifc.out_valid), 0);
        chk("mid_rst_cnt", 32'(fifo_count), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("mid_relat3", 32'(ifc.out_valid), 0);
        tick();
        chk("mid_relat4", 32'(ifc.out_valid), 1);
        chk("mid_re_bus", 32'(ifc.out_bus), 1);
        chk("mid_re_chan", 32'(ifc.out_chan), 8);
        chk("mid_re_cnt", 32'(fifo_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_grant_capture.md
Name: irq_grant_capture

Overview:
- Sequential stage directly downstream of the 27-channel priority interrupt decoder.
- Registers the decoder's bus-request flags (PA/PB/PC) and 4-bit channel code, and waits until they have been stable for a programmable number of cycles.
- Each settled grant is queued once as a {bus, channel} record in a small FIFO.
- The consumer (interrupt dispatcher) drains the FIFO through a valid/ready handshake.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
STABLE_CYCLES, 2, consecutive matching samples required before a grant is accepted; >= 1
CNT_W, 3, width of fifo_count; must hold DEPTH (default 3 bits)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
pa  in  1  decoder bus-A request flag (highest priority)
pb  in  1  decoder bus-B request flag
pc  in  1  decoder bus-C request flag (lowest priority)
chan  in  4  decoder channel code
out_valid  out  1  FIFO head record valid
out_ready  in  1  consumer accepts head record
out_bus  out  2  head bus code: 0=A, 1=B, 2=C; never 3
out_chan  out  4  head channel code
fifo_count  out  CNT_W  records held, 0..DEPTH
overflow  out  1  sticky: a settled grant was dropped because the FIFO was full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Input stage: {pa,pb,pc,chan} registered every cycle into in_q. No other path uses raw inputs.
- Active when any flag in in_q is set.
- Bus encoding is a priority reduction: pa -> 0, else pb -> 1, else pc -> 2.
- Sample key = {bus code, chan}. chan is ignored when no flag is active.
- FSM states: IDLE, SETTLE, HELD. Registers: snapshot key, settle counter cnt.
- IDLE:
  - in_q active -> SETTLE, snapshot <= key, cnt <= 0.
  - Otherwise stay in IDLE.
- SETTLE:
  - in_q inactive -> IDLE.
  - key != snapshot -> stay in SETTLE, snapshot <= key, cnt <= 0.
  - key == snapshot and cnt < STABLE_CYCLES-1 -> cnt++.
  - key == snapshot and cnt == STABLE_CYCLES-1 -> write snapshot to FIFO, go to HELD. If the FIFO is full, the write is dropped, overflow <= 1, and the FSM still goes to HELD.
- HELD:
  - key == snapshot -> stay in HELD. No re-push.
  - in_q inactive -> IDLE.
  - Different active key -> SETTLE with the new snapshot, cnt <= 0.
- Latency: the first out_valid for a record pushed into an empty FIFO rises STABLE_CYCLES+2 clock edges after the inputs are applied (1 input register + 1 IDLE->SETTLE edge + STABLE_CYCLES settle edges). Default: 4 edges.
- FIFO behaviour:
  - Show-ahead: out_bus/out_chan show the head record whenever out_valid=1. Both read 0 when the FIFO is empty.
  - Pop happens on a clock edge where out_valid && out_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and overflow is not set. fifo_count stays DEPTH.
  - Simultaneous push and pop when empty: the record appears the cycle after the push (no bypass). The pop does not occur because out_valid=0.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from fifo_count.
- overflow:
  - Sets on a dropped push.
  - clr_ovf clears it on the next edge.
  - If a drop and clr_ovf occur in the same cycle, set wins.
- out_valid, out_bus, out_chan and fifo_count are driven from registers or FIFO storage. There is no combinational path from any input to any output.
- Reset (asynchronous, any time, including mid-settle or with the FIFO non-empty):
  - FSM -> IDLE; cnt, snapshot and in_q -> 0.
  - FIFO pointers and count -> 0.
  - out_valid=0, out_bus=0, out_chan=0, fifo_count=0, overflow=0.
  - After rst deasserts, a request held steady re-settles from scratch.

Test Plan:
- Basic capture (STABLE_CYCLES=2): hold pb=1, chan=5 from cycle 0 -> out_valid=1 after edge 4 with out_bus=1, out_chan=5. With out_ready=0 the record stays and fifo_count=1. No second push while the input stays steady.
- Glitch filter: pa=1, chan=3 for 1 cycle, then chan=7 held -> only record {0,7} is queued. fifo_count never exceeds 1.
- Priority: pa=1, pb=1, pc=1, chan=9 held -> record out_bus=0, out_chan=9.
- Overflow: out_ready=0, present 5 distinct settled keys with idle gaps ({2,1},{2,2},{2,3},{2,4},{2,5}) -> fifo_count=4 and overflow=1. Draining yields chan 1, 2, 3, 4 in order. clr_ovf=1 for one cycle -> overflow=0.
- Full with simultaneous pop: FIFO at 4, out_ready=1 on the edge a new key settles -> fifo_count stays 4, overflow stays 0, the new record is at the tail.
- Reset mid-operation: assert rst during SETTLE with the FIFO holding 2 records -> immediately out_valid=0, fifo_count=0, overflow=0. After release with the input unchanged, the record reappears STABLE_CYCLES+2 edges later.
